// File: rtl/apb_master_if.sv
// APB bus bundle between the apb_master and its two slaves.
// The master drives selects, enable, address, write data and strobes;
// the selected slave returns PREADY and PRDATA.
interface apb_master_if #(
  parameter int PDATA_SIZE = 32
);
  logic                    PSEL1;
  logic                    PSEL2;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [PDATA_SIZE-1:0]   PADDR;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic                    PREADY;
  logic [PDATA_SIZE-1:0]   PRDATA;

  modport master (
    output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA
  );
endinterface

// File: rtl/apb_master.sv
// APB master: takes one request at a time from a valid/ready port, runs
// the SETUP/ACCESS sequence on one of two slaves and returns a one-cycle
// response pulse. A transfer stalled too long in ACCESS is aborted with
// rsp_err=1. All bus and response outputs come straight from flops.
module apb_master #(
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_slave,
  input  logic [PDATA_SIZE-1:0]   req_addr,
  input  logic [PDATA_SIZE-1:0]   req_wdata,
  input  logic [PDATA_SIZE/8-1:0] req_strb,
  output logic                    rsp_valid,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  apb_master_if.master            apb
);

  localparam int         STRB_W    = PDATA_SIZE / 8;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [7:0]            wait_cnt_r, wait_cnt_s;
  logic [7:0]            wait_cnt_inc_s;
  logic                  timeout_s;
  logic                  psel1_r, psel1_s;
  logic                  psel2_r, psel2_s;
  logic                  penable_r, penable_s;
  logic                  pwrite_r, pwrite_s;
  logic [PDATA_SIZE-1:0] paddr_r, paddr_s;
  logic [PDATA_SIZE-1:0] pwdata_r, pwdata_s;
  logic [STRB_W-1:0]     pstrb_r, pstrb_s;
  logic                  rsp_valid_r, rsp_valid_s;
  logic [PDATA_SIZE-1:0] rsp_rdata_r, rsp_rdata_s;
  logic                  rsp_err_r, rsp_err_s;

  // The wait count is the number of ACCESS edges already seen with PREADY
  // low; abort fires on the edge where that count would reach TIMEOUT.
  assign wait_cnt_inc_s = wait_cnt_r + 8'd1;
  assign timeout_s      = (!apb.PREADY) && (wait_cnt_inc_s == TIMEOUT_C);

  // State and output registers; synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 8'd0;
      psel1_r     <= 1'b0;
      psel2_r     <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {PDATA_SIZE{1'b0}};
      pwdata_r    <= {PDATA_SIZE{1'b0}};
      pstrb_r     <= {STRB_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {PDATA_SIZE{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      psel1_r     <= psel1_s;
      psel2_r     <= psel2_s;
      penable_r   <= penable_s;
      pwrite_r    <= pwrite_s;
      paddr_r     <= paddr_s;
      pwdata_r    <= pwdata_s;
      pstrb_r     <= pstrb_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

  // Next-state decode: SETUP always lasts one cycle, ACCESS ends on PREADY or timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb.PREADY || timeout_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered bus/response outputs and the wait counter.
  always_comb begin
    wait_cnt_s  = wait_cnt_r;
    psel1_s     = psel1_r;
    psel2_s     = psel2_r;
    penable_s   = penable_r;
    pwrite_s    = pwrite_r;
    paddr_s     = paddr_r;
    pwdata_s    = pwdata_r;
    pstrb_s     = pstrb_r;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = rsp_rdata_r;
    rsp_err_s   = rsp_err_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          // Reads carry no data or strobes on the bus.
          wait_cnt_s = 8'd0;
          psel1_s    = !req_slave;
          psel2_s    = req_slave;
          penable_s  = 1'b0;
          pwrite_s   = req_write;
          paddr_s    = req_addr;
          pwdata_s   = req_write ? req_wdata : {PDATA_SIZE{1'b0}};
          pstrb_s    = req_write ? req_strb : {STRB_W{1'b0}};
        end else begin
          psel1_s   = 1'b0;
          psel2_s   = 1'b0;
          penable_s = 1'b0;
        end
      end
      ST_SETUP: begin
        penable_s = 1'b1;
      end
      ST_ACCESS: begin
        if (apb.PREADY) begin
          psel1_s     = 1'b0;
          psel2_s     = 1'b0;
          penable_s   = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b0;
          rsp_rdata_s = pwrite_r ? {PDATA_SIZE{1'b0}} : apb.PRDATA;
        end else if (timeout_s) begin
          wait_cnt_s  = wait_cnt_inc_s;
          psel1_s     = 1'b0;
          psel2_s     = 1'b0;
          penable_s   = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          rsp_rdata_s = {PDATA_SIZE{1'b0}};
        end else begin
          wait_cnt_s = wait_cnt_inc_s;
        end
      end
      default: begin
        psel1_s   = 1'b0;
        psel2_s   = 1'b0;
        penable_s = 1'b0;
      end
    endcase
  end

  assign req_ready   = (state_r == ST_IDLE) && PRESETn;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign apb.PSEL1   = psel1_r;
  assign apb.PSEL2   = psel2_r;
  assign apb.PENABLE = penable_r;
  assign apb.PWRITE  = pwrite_r;
  assign apb.PADDR   = paddr_r;
  assign apb.PWDATA  = pwdata_r;
  assign apb.PSTRB   = pstrb_r;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter PDATA_SIZE, default 32, APB data and address width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum number of ACCESS cycles with PREADY low before the transfer is aborted (legal range 2..255).
REQ-003 SHALL have port PCLK, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port PRESETn, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, a transfer request is present.
REQ-006 SHALL have port req_ready, output, 1, block accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_slave, input, 1, target select: 0 drives PSEL1, 1 drives PSEL2.
REQ-009 SHALL have port req_addr, input, PDATA_SIZE, transfer address.
REQ-010 SHALL have port req_wdata, input, PDATA_SIZE, write data.
REQ-011 SHALL have port req_strb, input, PDATA_SIZE/8, write byte strobes.
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle pulse marking transfer completion.
REQ-013 SHALL have port rsp_rdata, output, PDATA_SIZE, read data, valid with rsp_valid.
REQ-014 SHALL have port rsp_err, output, 1, timeout indication, valid with rsp_valid.
REQ-015 SHALL have ports PSEL1 and PSEL2, output, 1 each, APB slave selects.
REQ-016 SHALL have port PENABLE, output, 1, APB access phase.
REQ-017 SHALL have ports PADDR and PWDATA, output, PDATA_SIZE each; PWRITE, output, 1; PSTRB, output, PDATA_SIZE/8.
REQ-018 SHALL have ports PREADY, input, 1, and PRDATA, input, PDATA_SIZE, from the selected slave.

Function
REQ-019 SHALL implement a three-state FSM: IDLE, SETUP, ACCESS.
REQ-020 SHALL assert req_ready only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-021 SHALL, on accept, register req_addr, req_write, req_wdata and req_strb onto the APB outputs, assert the selected PSELx, hold PENABLE=0, and go to SETUP.
REQ-022 SHALL drive PSTRB=0 and PWDATA=0 for read transfers.
REQ-023 SHALL go from SETUP to ACCESS unconditionally after exactly one cycle, setting PENABLE=1.
REQ-024 SHALL hold PADDR, PWRITE, PWDATA, PSTRB and PSELx stable from SETUP through the end of ACCESS.
REQ-025 SHALL complete the transfer on the first ACCESS-cycle edge with PREADY=1: deassert PSELx and PENABLE, return to IDLE, pulse rsp_valid for one cycle, set rsp_err=0, and set rsp_rdata=PRDATA for reads or 0 for writes.
REQ-026 SHALL count consecutive ACCESS cycles with PREADY=0; when the count reaches TIMEOUT, abort: deassert PSELx and PENABLE, return to IDLE, pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-027 SHALL clear the wait counter on entry to SETUP.
REQ-028 SHALL ignore PREADY and PRDATA outside ACCESS.
REQ-029 SHALL insert at least one IDLE cycle between transfers; minimum transfer-to-transfer period is 3 cycles with zero wait states.
REQ-030 SHALL hold rsp_rdata and rsp_err at their last values when rsp_valid=0.
REQ-031 SHALL never assert PSEL1 and PSEL2 in the same cycle.

Reset
REQ-032 SHALL, on any edge with PRESETn=0, force state IDLE, wait counter 0, and PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata and rsp_err all to 0; req_ready SHALL be 0 while PRESETn=0.
REQ-033 SHALL, when reset occurs mid-transfer, abandon the transfer without producing an rsp_valid pulse.

Verification
REQ-034 SHALL pass a zero-wait write: req_slave=0, addr=0xF700EF00, wdata=0xA5A5_5A5A, strb=4'hF, PREADY tied 1 -> PSEL1 high for 2 cycles with PENABLE high in the second, rsp_valid 1 cycle later with rsp_err=0.
REQ-035 SHALL pass a read with 3 wait states: req_slave=1, addr=0x0000_0000, PREADY low for 3 ACCESS cycles, then high with PRDATA=0x1234_5678 -> PSEL2 high for 5 cycles, rsp_rdata=0x1234_5678, PSTRB=0 throughout.
REQ-036 SHALL pass a timeout: PREADY held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0, FSM back in IDLE.
REQ-037 SHALL pass back-to-back requests: req_valid held high with two queued requests -> second SETUP begins 3 cycles after first SETUP, req_ready low during SETUP/ACCESS.
REQ-038 SHALL pass reset during ACCESS: PRESETn=0 for 1 cycle while PREADY=0 -> all APB outputs 0 next edge, no rsp_valid pulse, next request proceeds normally.
REQ-039 SHALL pass a partial-strobe write: strb=4'b0101, wdata=0xDEAD_BEEF -> PSTRB=4'b0101 and PWDATA=0xDEAD_BEEF stable through SETUP and ACCESS.
